seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 70 +++++++
 tb/tb_seg_scan_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit 7-seg scan with blanking and frame-synced double buffer (in: clk_i rst_i en_i seg_i upd_valid_i; out: upd_ready_o an_o seg_o frame_o)
module seg_scan_ctrl #(
  parameter int ON_CYC = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [55:0] seg_i,
  input  logic        upd_valid_i,
  output logic        upd_ready_o,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        frame_o
);
  localparam int MAXC = ON_CYC > BLANK_CYC ? ON_CYC : BLANK_CYC;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_ON = 2'd2;
  logic [1:0]    r_state;
  logic [2:0]    r_dig;
  logic [CW-1:0] r_cnt;
  logic [55:0]   r_act;
  logic [55:0]   r_pend;
  logic          r_pend_v;
  logic          w_last;
  logic          w_wrap;
  logic          w_bound;
  logic          w_copy;
  logic          w_acc;
  logic [1:0]    w_nstate;
  logic [2:0]    w_ndig;
  logic [CW-1:0] w_ncnt;
  always_comb begin
    w_last = r_state == S_BLANK ? r_cnt == CW'(BLANK_CYC - 1) : r_cnt == CW'(ON_CYC - 1);
    w_wrap = r_state == S_ON && en_i && w_last && r_dig == 3'd7;
    w_bound = (r_state == S_IDLE && en_i) || w_wrap;
    w_copy = r_pend_v && (r_state == S_IDLE || w_wrap);
    w_acc = upd_valid_i && !r_pend_v;
    w_nstate = !en_i ? S_IDLE : r_state == S_IDLE ? S_BLANK : !w_last ? r_state :
               r_state == S_BLANK ? S_ON : S_BLANK;
    w_ndig = (!en_i || r_state == S_IDLE) ? 3'd0 : (r_state == S_ON && w_last) ? r_dig + 3'd1 : r_dig;
    w_ncnt = (!en_i || r_state == S_IDLE || w_last) ? '0 : r_cnt + CW'(1);
  end
  assign upd_ready_o = ~r_pend_v;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_dig <= 3'd0;
      r_cnt <= '0;
      r_act <= '1;
      r_pend <= '1;
      r_pend_v <= 1'b0;
      an_o <= 8'hFF;
      seg_o <= 7'h7F;
      frame_o <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_dig <= w_ndig;
      r_cnt <= w_ncnt;
      r_act <= w_copy ? r_pend : r_act;
      r_pend <= w_acc ? seg_i : r_pend;
      r_pend_v <= w_acc ? 1'b1 : w_copy ? 1'b0 : r_pend_v;
      an_o <= w_nstate == S_ON ? ~(8'b1 << w_ndig) : 8'hFF;
      seg_o <= w_nstate == S_ON ? r_act[7*w_ndig +: 7] : 7'h7F;
      frame_o <= w_bound;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed table, corner sequences and random run against a frame-position model
module tb_seg_scan_ctrl;
  localparam int ON = 4;
  localparam int BL = 2;
  localparam int SLOT = ON + BL;
  localparam int FR = 8 * SLOT;
  typedef struct {
    logic        r;
    logic        e;
    logic        v;
    logic [55:0] s;
    logic [7:0]  an;
    logic [6:0]  sg;
    logic        fr;
    logic        rd;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        valid;
  logic [55:0] seg;
  logic        rdy;
  logic [7:0]  an;
  logic [6:0]  so;
  logic        frame;
  int checks = 0;
  int fails = 0;
  logic       m_run;
  int         m_t;
  logic [6:0] m_act [8];
  logic [6:0] m_pend [8];
  logic       m_pv;
  always #5 clk = ~clk;
  seg_scan_ctrl #(.ON_CYC(ON), .BLANK_CYC(BL)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .seg_i(seg), .upd_valid_i(valid),
    .upd_ready_o(rdy), .an_o(an), .seg_o(so), .frame_o(frame)
  );
  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got an/seg/frame/rdy=%h/%h/%b/%b want %h/%h/%b/%b", name, $time,
               act[16:9], act[8:2], act[1], act[0], exp[16:9], exp[8:2], exp[1], exp[0]);
    end
  endtask
  function automatic logic [16:0] model_out();
    int sl;
    sl = m_t / SLOT;
    if (m_run && (m_t % SLOT) >= BL) return {~(8'b1 << sl), m_act[sl], 1'b0, !m_pv};
    return {8'hFF, 7'h7F, m_run && m_t == 0, !m_pv};
  endfunction
  task automatic model_copy();
    for (int i = 0; i < 8; i++) m_act[i] = m_pend[i];
    m_pv = 1'b0;
  endtask
  task automatic model_edge(input logic r, input logic e, input logic v, input logic [55:0] s);
    logic acc;
    acc = v && !m_pv;
    if (r) begin
      m_run = 1'b0;
      m_t = 0;
      m_pv = 1'b0;
      for (int i = 0; i < 8; i++) m_act[i] = 7'h7F;
    end else begin
      if (!m_run) begin
        if (m_pv) model_copy();
        if (e) begin
          m_run = 1'b1;
          m_t = 0;
        end
      end else if (!e) m_run = 1'b0;
      else begin
        m_t = (m_t + 1) % FR;
        if (m_t == 0 && m_pv) model_copy();
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) m_pend[i] = s[7*i +: 7];
        m_pv = 1'b1;
      end
    end
  endtask
  task automatic step(input logic r, input logic e, input logic v, input logic [55:0] s);
    @(negedge clk);
    rst = r;
    en = e;
    valid = v;
    seg = s;
    @(posedge clk);
    model_edge(r, e, v, s);
    #1;
    chk("model", {an, so, frame, rdy}, model_out());
  endtask
  task automatic run_to(input int t);
    for (int k = 0; k < 2 * FR && !(m_run && m_t == t); k++) step(0, 1, 0, '0);
  endtask
  function automatic vec_t mk(input logic r, input logic e, input logic v, input logic [55:0] s,
                              input logic [7:0] a, input logic [6:0] g, input logic f, input logic d);
    vec_t x;
    x.r = r; x.e = e; x.v = v; x.s = s; x.an = a; x.sg = g; x.fr = f; x.rd = d;
    return x;
  endfunction
  initial begin
    vec_t tbl [18];
    logic [55:0] fa;
    logic [55:0] fb;
    logic [55:0] fc;
    logic [55:0] fd;
    int n;
    fa = {{5{7'h7F}}, 7'h30, 7'h24, 7'h40};
    fb = {{7{7'h3F}}, 7'h12};
    fc = {{7{7'h00}}, 7'h55};
    fd = {{7{7'h0F}}, 7'h01};
    tbl[0] = mk(1, 0, 0, '0, 8'hFF, 7'h7F, 1, 1);
    tbl[0].fr = 0;
    tbl[1] = mk(0, 0, 1, fa, 8'hFF, 7'h7F, 0, 0);
    tbl[2] = mk(0, 0, 0, '0, 8'hFF, 7'h7F, 0, 1);
    tbl[3] = mk(0, 1, 0, '0, 8'hFF, 7'h7F, 1, 1);
    tbl[4] = mk(0, 1, 0, '0, 8'hFF, 7'h7F, 0, 1);
    for (int i = 5; i < 9; i++) tbl[i] = mk(0, 1, 0, '0, 8'hFE, 7'h40, 0, 1);
    for (int i = 9; i < 11; i++) tbl[i] = mk(0, 1, 0, '0, 8'hFF, 7'h7F, 0, 1);
    for (int i = 11; i < 15; i++) tbl[i] = mk(0, 1, 0, '0, 8'hFD, 7'h24, 0, 1);
    for (int i = 15; i < 17; i++) tbl[i] = mk(0, 1, 0, '0, 8'hFF, 7'h7F, 0, 1);
    tbl[17] = mk(0, 1, 0, '0, 8'hFB, 7'h30, 0, 1);
    m_run = 0; m_t = 0; m_pv = 0;
    for (int i = 0; i < 8; i++) begin
      m_act[i] = 7'h7F;
      m_pend[i] = 7'h7F;
    end
    rst = 1; en = 0; valid = 0; seg = '0;
    step(1, 0, 0, '0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, '0);
      chk("idle_dark", {an, so, frame, rdy}, {8'hFF, 7'h7F, 1'b0, 1'b1});
    end
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].s);
      chk("table", {an, so, frame, rdy}, {tbl[i].an, tbl[i].sg, tbl[i].fr, tbl[i].rd});
    end
    n = 0;
    for (int k = 0; k < 100; k++) begin
      step(0, 1, 0, '0);
      n++;
      if (frame) break;
    end
    chk("frame_period", {9'd0, 8'(n)}, {9'd0, 8'(FR - 14)});
    run_to(10);
    step(0, 1, 1, fb);
    chk("rdy_after_load", {16'd0, rdy}, 17'd0);
    step(0, 1, 1, fc);
    run_to(BL);
    chk("b_shown", {an, so, frame, rdy}, {8'hFE, 7'h12, 1'b0, 1'b1});
    run_to(FR - 1);
    step(0, 1, 1, fd);
    run_to(BL);
    chk("d_not_yet", {an, so, frame, rdy}, {8'hFE, 7'h12, 1'b0, 1'b0});
    run_to(0);
    run_to(BL);
    chk("d_shown", {an, so, frame, rdy}, {8'hFE, 7'h01, 1'b0, 1'b1});
    run_to(5 * SLOT + BL + 1);
    step(0, 0, 0, '0);
    chk("drop_en", {an, so, frame, rdy}, {8'hFF, 7'h7F, 1'b0, 1'b1});
    step(0, 1, 0, '0);
    chk("restart", {an, so, frame, rdy}, {8'hFF, 7'h7F, 1'b1, 1'b1});
    run_to(3 * SLOT + BL);
    step(1, 1, 1, fc);
    chk("mid_reset", {an, so, frame, rdy}, {8'hFF, 7'h7F, 1'b0, 1'b1});
    run_to(BL);
    chk("act_reset", {an, so, frame, rdy}, {8'hFE, 7'h7F, 1'b0, 1'b1});
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0,
           {$urandom, $urandom});
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
